// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Serial pattern detector for an N-bit PATTERN. PATTERN[N-1] is the first bit
// received. The detector can allow overlapping matches or restart after each
// match, can drive y combinationally (Mealy) or one clock later (registered),
// and keeps a saturating count of matches.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        synchronous, active-high; wins over x_valid and clear_cnt
//   x            serial data bit
//   x_valid      qualifier; x is ignored and all state holds while low
//   clear_cnt    synchronous clear of match_count (loads 1 on a same-cycle match)
//   y            match pulse (Mealy when REG_OUT=0, delayed one clock when 1)
//   depth        current partial-match length, 0..N-1
//   match_count  number of matches, saturating at all-ones
//
// State is the partial-match depth:
//   depth   | meaning
//   0       | no prefix of PATTERN matched
//   k       | last k accepted bits equal PATTERN[N-1:N-k]
//   N-1     | next bit equal to PATTERN[0] completes a match
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1101,
    parameter bit             OVERLAP = 1'b1,
    parameter bit             REG_OUT = 1'b0,
    parameter int             CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   x,
    input  logic                   x_valid,
    input  logic                   clear_cnt,
    output logic                   y,
    output logic [$clog2(N)-1:0]   depth,
    output logic [CNT_W-1:0]       match_count
);

    localparam int DW = $clog2(N);

    // Longest proper border of PATTERN: the longest prefix that is also a suffix.
    function automatic int longest_border();
        int b;
        b = 0;
        for (int k = 1; k < N; k++) begin
            if ((PATTERN >> (N - k)) == (PATTERN & ({N{1'b1}} >> (N - k))))
                b = k;
        end
        return b;
    endfunction

    localparam int            BORDER   = longest_border();
    localparam logic [DW-1:0] LAST_D   = DW'(N - 1);
    localparam logic [DW-1:0] BORDER_D = DW'(BORDER);

    logic [DW-1:0]    depth_q, depth_d;
    logic [N-2:0]     hist_q, hist_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic             y_q, y_d;

    logic [N-1:0]     window;
    logic             match_now;
    logic             y_comb;
    int               nxt_len;

    always_comb begin
        window    = {hist_q, x};
        match_now = x_valid && (depth_q == LAST_D) && (x == PATTERN[0]);
        y_comb    = match_now && !reset;

        // Longest suffix of the window that is a prefix of PATTERN. Lengths are
        // capped at depth+1 so bits older than the current partial match (from
        // before a reset or a non-overlapping restart) never count.
        nxt_len = 0;
        for (int k = 1; k < N; k++) begin
            if ((k <= int'(depth_q) + 1) &&
                (((window ^ (PATTERN >> (N - k))) & ({N{1'b1}} >> (N - k))) == '0))
                nxt_len = k;
        end

        depth_d       = depth_q;
        hist_d        = hist_q;
        match_count_d = match_count_q;
        y_d           = y_comb;

        if (x_valid) begin
            hist_d = window[N-2:0];
            if (match_now)
                depth_d = OVERLAP ? BORDER_D : '0;
            else
                depth_d = DW'(nxt_len);
        end

        if (clear_cnt)
            match_count_d = match_now ? CNT_W'(1) : '0;
        else if (match_now && (match_count_q != '1))
            match_count_d = match_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q       <= '0;
            hist_q        <= '0;
            match_count_q <= '0;
            y_q           <= 1'b0;
        end else begin
            depth_q       <= depth_d;
            hist_q        <= hist_d;
            match_count_q <= match_count_d;
            y_q           <= y_d;
        end
    end

    assign y           = REG_OUT ? y_q : y_comb;
    assign depth       = depth_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

    logic clk;
    logic reset;
    logic x;
    logic x_valid;
    logic clear_cnt;

    // a: defaults (1101, overlap, Mealy)
    logic       a_y;
    logic [1:0] a_depth;
    logic [7:0] a_count;
    // b: 1101, no overlap
    logic       b_y;
    logic [1:0] b_depth;
    logic [7:0] b_count;
    // c: 1101, registered output, 2-bit counter
    logic       c_y;
    logic [1:0] c_depth;
    logic [1:0] c_count;
    // d: N=5, 10100, overlap
    logic       d_y;
    logic [2:0] d_depth;
    logic [7:0] d_count;

    int checks = 0;
    int errors = 0;

    seq_detector_param u_a (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear_cnt(clear_cnt),
        .y(a_y), .depth(a_depth), .match_count(a_count));

    seq_detector_param #(.OVERLAP(1'b0)) u_b (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear_cnt(clear_cnt),
        .y(b_y), .depth(b_depth), .match_count(b_count));

    seq_detector_param #(.REG_OUT(1'b1), .CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear_cnt(clear_cnt),
        .y(c_y), .depth(c_depth), .match_count(c_count));

    seq_detector_param #(.N(5), .PATTERN(5'b10100)) u_d (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .clear_cnt(clear_cnt),
        .y(d_y), .depth(d_depth), .match_count(d_count));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled 2 units later.
    task automatic put(input logic xb, input logic vb);
        x       = xb;
        x_valid = vb;
        #2;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        x         = 1'b0;
        x_valid   = 1'b0;
        clear_cnt = 1'b0;
        clk_edge();
        clk_edge();
        reset = 1'b0;
    endtask

    task automatic step_a(input string tag, input logic xb, input logic vb,
                          input logic ey, input int ed);
        put(xb, vb);
        chk({tag, ".y"}, 32'(a_y), 32'(ey));
        clk_edge();
        chk({tag, ".depth"}, 32'(a_depth), 32'(ed));
    endtask

    task automatic step_ab(input string tag, input logic xb, input logic eya, input logic eyb);
        put(xb, 1'b1);
        chk({tag, ".ya"}, 32'(a_y), 32'(eya));
        chk({tag, ".yb"}, 32'(b_y), 32'(eyb));
        clk_edge();
    endtask

    task automatic step_d(input string tag, input logic xb, input logic ey, input int ed);
        put(xb, 1'b1);
        chk({tag, ".y"}, 32'(d_y), 32'(ey));
        clk_edge();
        chk({tag, ".depth"}, 32'(d_depth), 32'(ed));
    endtask

    initial begin
        reset     = 1'b1;
        x         = 1'b1;
        x_valid   = 1'b1;
        clear_cnt = 1'b0;
        clk_edge();
        clk_edge();
        #2;
        chk("rst.depth", 32'(a_depth), 0);
        chk("rst.count", 32'(a_count), 0);
        chk("rst.ya", 32'(a_y), 0);
        chk("rst.yc", 32'(c_y), 0);
        chk("rst.countc", 32'(c_count), 0);
        do_reset();

        // basic detection 1101
        step_a("basic1", 1'b1, 1'b1, 1'b0, 1);
        step_a("basic2", 1'b1, 1'b1, 1'b0, 2);
        step_a("basic3", 1'b0, 1'b1, 1'b0, 3);
        step_a("basic4", 1'b1, 1'b1, 1'b1, 1);
        chk("basic.count", 32'(a_count), 1);

        // overlap vs non-overlap on 1,1,0,1,1,0,1
        do_reset();
        step_ab("ovl1", 1'b1, 1'b0, 1'b0);
        step_ab("ovl2", 1'b1, 1'b0, 1'b0);
        step_ab("ovl3", 1'b0, 1'b0, 1'b0);
        step_ab("ovl4", 1'b1, 1'b1, 1'b1);
        step_ab("ovl5", 1'b1, 1'b0, 1'b0);
        step_ab("ovl6", 1'b0, 1'b0, 1'b0);
        step_ab("ovl7", 1'b1, 1'b1, 1'b0);
        chk("ovl.counta", 32'(a_count), 2);
        chk("ovl.countb", 32'(b_count), 1);
        chk("ovl.depthb", 32'(b_depth), 1);

        // failure transitions
        do_reset();
        step_a("fail1", 1'b1, 1'b1, 1'b0, 1);
        step_a("fail2", 1'b1, 1'b1, 1'b0, 2);
        step_a("fail3", 1'b1, 1'b1, 1'b0, 2);
        step_a("fail4", 1'b0, 1'b1, 1'b0, 3);
        step_a("fail5", 1'b1, 1'b1, 1'b1, 1);
        do_reset();
        step_a("drop1", 1'b1, 1'b1, 1'b0, 1);
        step_a("drop2", 1'b1, 1'b1, 1'b0, 2);
        step_a("drop3", 1'b0, 1'b1, 1'b0, 3);
        step_a("drop4", 1'b0, 1'b1, 1'b0, 0);

        // qualifier gaps
        do_reset();
        step_a("gap1", 1'b1, 1'b1, 1'b0, 1);
        step_a("gap2", 1'b1, 1'b1, 1'b0, 2);
        step_a("gap3", 1'b0, 1'b0, 1'b0, 2);
        step_a("gap4", 1'b0, 1'b0, 1'b0, 2);
        step_a("gap5", 1'b0, 1'b0, 1'b0, 2);
        step_a("gap6", 1'b0, 1'b1, 1'b0, 3);
        step_a("gap7", 1'b1, 1'b1, 1'b1, 1);
        chk("gap.count", 32'(a_count), 1);

        // mid-pattern reset; y must be gated while reset is high at depth 3
        do_reset();
        step_a("mid1", 1'b1, 1'b1, 1'b0, 1);
        step_a("mid2", 1'b1, 1'b1, 1'b0, 2);
        step_a("mid3", 1'b0, 1'b1, 1'b0, 3);
        reset = 1'b1;
        put(1'b1, 1'b1);
        chk("mid.rst.y", 32'(a_y), 0);
        clk_edge();
        reset = 1'b0;
        chk("mid.rst.depth", 32'(a_depth), 0);
        step_a("mid4", 1'b1, 1'b1, 1'b0, 1);
        chk("mid.count", 32'(a_count), 0);

        // registered mode, saturation, clear on a matching cycle
        do_reset();
        for (int g = 0; g < 6; g++) begin
            for (int b = 0; b < 4; b++) begin
                clear_cnt = (g == 5 && b == 3);
                put((b == 2) ? 1'b0 : 1'b1, 1'b1);
                chk($sformatf("reg.g%0d.b%0d.yc", g, b), 32'(c_y), 32'((g > 0 && b == 0)));
                chk($sformatf("reg.g%0d.b%0d.ya", g, b), 32'(a_y), 32'((b == 3)));
                clk_edge();
            end
            clear_cnt = 1'b0;
            chk($sformatf("reg.g%0d.count", g), 32'(c_count),
                (g == 5) ? 1 : ((g + 1 > 3) ? 3 : g + 1));
        end
        put(1'b0, 1'b0);
        chk("reg.tail.yc", 32'(c_y), 1);
        clk_edge();
        put(1'b0, 1'b0);
        chk("reg.idle.yc", 32'(c_y), 0);
        clk_edge();

        // generic N=5 pattern 10100
        do_reset();
        step_d("gen1", 1'b1, 1'b0, 1);
        step_d("gen2", 1'b0, 1'b0, 2);
        step_d("gen3", 1'b1, 1'b0, 3);
        step_d("gen4", 1'b0, 1'b0, 4);
        step_d("gen5", 1'b1, 1'b0, 3);
        step_d("gen6", 1'b0, 1'b0, 4);
        step_d("gen7", 1'b0, 1'b1, 0);
        chk("gen.count", 32'(d_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
